// File: rtl/axi_addr_trace.sv
// axi_addr_trace: passive AW/AR address capture into two independent circular trace buffers
// with saturating handshake counters, fill levels, sticky overflow and registered oldest-first readback.
module axi_addr_trace #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    parameter bit WRAP   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       awvalid,
    input  logic                       awready,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic                       arvalid,
    input  logic                       arready,
    input  logic [ADDR_W-1:0]          araddr,
    input  logic                       rd_sel,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [ADDR_W-1:0]          rd_data,
    output logic [CNT_W-1:0]           aw_count,
    output logic [CNT_W-1:0]           ar_count,
    output logic [$clog2(DEPTH):0]     aw_level,
    output logic [$clog2(DEPTH):0]     ar_level,
    output logic                       aw_overflow,
    output logic                       ar_overflow
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL_LVL = (IW+1)'(DEPTH);

    logic [1:0]        hs;
    logic [ADDR_W-1:0] addr [2];
    logic [ADDR_W-1:0] rd_val [2];
    logic [IW:0]       lvl [2];
    logic [CNT_W-1:0]  cnt [2];
    logic [1:0]        ovf;
    logic [ADDR_W-1:0] rd_data_q;

    assign hs      = {arvalid && arready, awvalid && awready};
    assign addr[0] = awaddr;
    assign addr[1] = araddr;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [ADDR_W-1:0] mem [DEPTH];
        logic [IW-1:0]     ptr_q, oldest, phys;
        logic [IW:0]       lvl_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              ovf_q, full, store;
        assign full   = lvl_q == FULL_LVL;
        assign store  = hs[c] && (!full || WRAP);
        // Once a wrapping buffer is full, the write pointer marks the oldest entry.
        assign oldest = (WRAP && full) ? ptr_q : '0;
        assign phys   = oldest + rd_idx;
        assign rd_val[c] = ({1'b0, rd_idx} < lvl_q) ? mem[phys] : '0;
        assign lvl[c] = lvl_q;
        assign cnt[c] = cnt_q;
        assign ovf[c] = ovf_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_q <= '0;
                lvl_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (clear) begin
                ptr_q <= '0;
                lvl_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (hs[c]) begin
                cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                ovf_q <= ovf_q | full;
                if (store) begin
                    ptr_q <= ptr_q + IW'(1);
                    lvl_q <= full ? lvl_q : lvl_q + (IW+1)'(1);
                end
            end
        end
        always_ff @(posedge clk) begin
            if (rst_n && !clear && store) mem[ptr_q] <= addr[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= clear ? '0 : rd_val[rd_sel];
    end

    assign rd_data     = rd_data_q;
    assign aw_count    = cnt[0];
    assign ar_count    = cnt[1];
    assign aw_level    = lvl[0];
    assign ar_level    = lvl[1];
    assign aw_overflow = ovf[0];
    assign ar_overflow = ovf[1];
endmodule
